// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// state encoding and the datapath control word.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // State that follows DECODE for a given opcode; FETCH means the opcode is illegal.
    function automatic state_t decode_target(input logic [5:0] op, input logic en_bne);
        state_t nxt;
        case (op)
            OP_RTYPE:                         nxt = S_EXEC_R;
            OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXEC_I;
            OP_BEQ:                           nxt = S_BRANCH;
            OP_BNE:                           nxt = en_bne ? S_BRANCH : S_FETCH;
            OP_J:                             nxt = S_JUMP;
            default:                          nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mcu_out_decode.sv
// Combinational control-word decode from the current state, memory handshake
// and opcode (live opcode for the DECODE legality check, latched one afterwards).
module mcu_out_decode
    import mcu_pkg::*;
#(
    parameter bit EN_BNE = 1'b1
) (
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] op_q,
    output ctrl_t      ctrl
);

    // Moore control word per state; only FETCH/MEM_WR enables look at mem_ready.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'b11;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = (decode_target(opcode, EN_BNE) == S_FETCH);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_R;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_XORI: ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.branch_ne     = (op_q == OP_BNE);
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, opcode
// latch and retired-instruction counter around the control-word decoder.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3,
    parameter bit EN_BNE   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       op_in;
    ctrl_t            ctrl, ctrl_o;

    assign op_in = 6'(opcode);

    mcu_out_decode #(.EN_BNE(EN_BNE)) u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (op_in),
        .op_q      (op_q),
        .ctrl      (ctrl)
    );

    // Next state, opcode capture in DECODE and retire counting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q + CNT_W'(ctrl.instr_done);
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d    = op_in;
                state_d = decode_target(op_in, EN_BNE);
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, latched opcode and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin
        ctrl_o = reset ? '0 : ctrl;
    end

    assign pc_write      = ctrl_o.pc_write;
    assign pc_write_cond = ctrl_o.pc_write_cond;
    assign branch_ne     = ctrl_o.branch_ne;
    assign i_or_d        = ctrl_o.i_or_d;
    assign mem_read      = ctrl_o.mem_read;
    assign mem_write     = ctrl_o.mem_write;
    assign ir_write      = ctrl_o.ir_write;
    assign mem_to_reg    = ctrl_o.mem_to_reg;
    assign reg_dst       = ctrl_o.reg_dst;
    assign reg_write     = ctrl_o.reg_write;
    assign alu_src_a     = ctrl_o.alu_src_a;
    assign alu_src_b     = ctrl_o.alu_src_b;
    assign alu_op        = ALU_OP_W'(ctrl_o.alu_op);
    assign pc_source     = ctrl_o.pc_source;
    assign instr_done    = ctrl_o.instr_done;
    assign illegal_op    = ctrl_o.illegal_op;
    assign instr_count   = count_q;

endmodule
